// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: loads a parallel word over a valid/ready handshake,
// holds it on the mux data bus and steps the mux select one position per
// clock, producing a parallel-in/serial-out stream at the mux output.
// Build option: define MUX_SEQ_MSB_FIRST_EN for an MSB-first stream
// (select counts down from NBITS-1). Default build is LSB first.
module mux_sel_sequencer #(
   parameter int NBITS = 8,   // word width, must equal 2**SW
   parameter int SW    = 3    // select width
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [NBITS-1:0] din,
   output logic             load_ready,
   input  logic             stall,
   output logic [NBITS-1:0] a,
   output logic [SW-1:0]    s,
   output logic             en,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

`ifdef MUX_SEQ_MSB_FIRST_EN
   // MSB first: start at the top position and count down to 0.
   localparam logic [SW-1:0] FIRST_POS = SW'(NBITS - 1);
   localparam logic [SW-1:0] LAST_POS  = '0;
`else
   // LSB first: start at position 0 and count up to NBITS-1.
   localparam logic [SW-1:0] FIRST_POS = '0;
   localparam logic [SW-1:0] LAST_POS  = SW'(NBITS - 1);
`endif

   state_t        state;
   logic          at_last;
   logic [SW-1:0] s_next;

   assign at_last = (s == LAST_POS);

   // Next select position inside a word; never evaluated past the last one.
`ifdef MUX_SEQ_MSB_FIRST_EN
   assign s_next = s - SW'(1);
`else
   assign s_next = s + SW'(1);
`endif

   // Ready whenever idle, or on the unstalled last position so words can
   // follow each other without a gap.
   assign load_ready = (state == IDLE) || (at_last && !stall);

   assign busy = (state == SEND);

   // Handshake, select stepping and done pulse; all outputs registered.
   // NOTE: every state element here uses <= so all registers update from
   // the same pre-edge values, whatever order the statements are written in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a     <= '0;
         s     <= '0;
         en    <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load_valid) begin
                  a     <= din;
                  s     <= FIRST_POS;
                  en    <= 1'b1;
                  state <= SEND;
               end
            end
            SEND: begin
               // A stall freezes a, s and en: the mux keeps the same bit.
               if (!stall) begin
                  if (at_last) begin
                     done <= 1'b1;
                     if (load_valid) begin
                        a <= din;
                        s <= FIRST_POS;
                     end else begin
                        en    <= 1'b0;
                        state <= IDLE;
                     end
                  end else begin
                     s <= s_next;
                  end
               end
            end
            default: begin
               state <= IDLE;
               en    <= 1'b0;
            end
         endcase
      end
   end

endmodule
